// File: rtl/urv_mdu_pkg.sv
// Shared types and constants for the multiply/divide unit issue logic.
// Func3 encodings mirror the RISC-V M-extension R-type divide group.
package urv_mdu_pkg;

  localparam int XLEN = 32;
  localparam int RD_W = 5;

  localparam logic [2:0] R_INST_FUNC3_DIV  = 3'b100;
  localparam logic [2:0] R_INST_FUNC3_DIVU = 3'b101;
  localparam logic [2:0] R_INST_FUNC3_REM  = 3'b110;
  localparam logic [2:0] R_INST_FUNC3_REMU = 3'b111;

  localparam logic [XLEN-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] DIV_OVF_QUOT  = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESP   = 3'd4
  } div_issue_state_t;

endpackage

// File: rtl/div_issue_if.sv
// Request, divider and response signals of the divide issue block.
// master = the issue block, slave = execute/divider/writeback side.
interface div_issue_if;
  import urv_mdu_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_func3;
  logic [XLEN-1:0] req_rs1;
  logic [XLEN-1:0] req_rs2;
  logic [RD_W-1:0] req_rd;

  logic            div_op_valid;
  logic            div_op_stall;
  logic [2:0]      div_op;
  logic [XLEN-1:0] div_op1;
  logic [XLEN-1:0] div_op2;
  logic            div_op_ready;
  logic [XLEN-1:0] div_op_out;

  logic            resp_valid;
  logic            resp_ready;
  logic [RD_W-1:0] resp_rd;
  logic [XLEN-1:0] resp_data;

  modport master (
    input  req_valid, req_func3, req_rs1, req_rs2, req_rd,
    input  div_op_ready, div_op_out, resp_ready,
    output req_ready, div_op_valid, div_op_stall, div_op, div_op1, div_op2,
    output resp_valid, resp_rd, resp_data
  );

  modport slave (
    output req_valid, req_func3, req_rs1, req_rs2, req_rd,
    output div_op_ready, div_op_out, resp_ready,
    input  req_ready, div_op_valid, div_op_stall, div_op, div_op1, div_op2,
    input  resp_valid, resp_rd, resp_data
  );

endinterface

// File: rtl/div_special.sv
// Resolves divide-by-zero and signed-overflow results without the divider.
// Purely combinational; the caller registers the result.
module div_special
  import urv_mdu_pkg::*;
(
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            is_special,
  output logic [XLEN-1:0] special_data
);

  logic div_zero;
  logic ovf;

  assign div_zero = (rs2 == '0);
  assign ovf      = (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);

  always_comb begin
    is_special   = 1'b0;
    special_data = '0;
    unique case (func3)
      R_INST_FUNC3_DIV: begin
        is_special   = div_zero || ovf;
        special_data = div_zero ? DIV_ZERO_QUOT : DIV_OVF_QUOT;
      end
      R_INST_FUNC3_DIVU: begin
        is_special   = div_zero;
        special_data = DIV_ZERO_QUOT;
      end
      R_INST_FUNC3_REM: begin
        // Overflow remainder is zero, which is already the default data.
        is_special   = div_zero || ovf;
        special_data = div_zero ? rs1 : '0;
      end
      R_INST_FUNC3_REMU: begin
        is_special   = div_zero;
        special_data = rs1;
      end
      default: begin
        is_special   = 1'b0;
        special_data = '0;
      end
    endcase
  end

endmodule

// File: rtl/div_issue.sv
// Initiator side of the iterative divider handshake: accepts one divide op,
// launches the divider (or resolves special cases locally) and returns the result.
module div_issue
  import urv_mdu_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       kill,
  input  logic       hold,
  div_issue_if.master bus
);

  div_issue_state_t state_q, state_d;

  logic [2:0]      op_q;
  logic [XLEN-1:0] op1_q;
  logic [XLEN-1:0] op2_q;
  logic [XLEN-1:0] res_q;
  logic [RD_W-1:0] rd_q;

  logic            accept;
  logic            capture_result;
  logic            req_ready;
  logic            op_valid;
  logic            op_stall;
  logic            resp_valid;
  logic            is_special;
  logic [XLEN-1:0] special_data;

  div_special u_special (
    .func3        (bus.req_func3),
    .rs1          (bus.req_rs1),
    .rs2          (bus.req_rs2),
    .is_special   (is_special),
    .special_data (special_data)
  );

  assign accept = (state_q == ST_IDLE) && bus.req_valid && !kill;

  always_comb begin
    state_d        = state_q;
    req_ready      = 1'b0;
    op_valid       = 1'b0;
    op_stall       = 1'b0;
    resp_valid     = 1'b0;
    capture_result = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = !kill;
        if (accept) state_d = is_special ? ST_RESP : ST_LAUNCH;
      end
      ST_LAUNCH: begin
        // Launch pulse is re-presented every cycle the divider is frozen.
        op_valid = 1'b1;
        op_stall = hold;
        if (kill)       state_d = ST_DRAIN;
        else if (!hold) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        op_stall = hold;
        if (bus.div_op_ready) begin
          capture_result = !kill;
          state_d        = kill ? ST_IDLE : ST_RESP;
        end else if (kill) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The divider cannot abort; swallow its result before accepting again.
        op_stall = hold;
        if (bus.div_op_ready) state_d = ST_IDLE;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (kill || bus.resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      rd_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= bus.req_func3;
        op1_q <= bus.req_rs1;
        op2_q <= bus.req_rs2;
        rd_q  <= bus.req_rd;
      end
      if (accept && is_special) res_q <= special_data;
      else if (capture_result)  res_q <= bus.div_op_out;
    end
  end

  assign bus.req_ready    = req_ready;
  assign bus.div_op_valid = op_valid;
  assign bus.div_op_stall = op_stall;
  assign bus.div_op       = op_q;
  assign bus.div_op1      = op1_q;
  assign bus.div_op2      = op2_q;
  assign bus.resp_valid   = resp_valid;
  assign bus.resp_rd      = rd_q;
  assign bus.resp_data    = res_q;

endmodule
